main_ram_arbiter: RTL and testbench

Sequences the single SDRAM controller port (addr/rd/wr/word/din/dout/busy) and shares it between three requesters: the SNES core (ROM fetch and BSRAM access), the game loader (ROM image writes), and the ESP32 save-RAM backup port (BSRAM read/write over SPI). It sits in the clk_sys domain between those masters and the `sdram` instance. It replaces the combinational `load_done` mux with a registered, handshaked, priority-with-anti-starvation scheduler.

---
 rtl/main_ram_arbiter_if.sv | 65 ++++++
 rtl/main_ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_main_ram_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : main_ram_arbiter_if
// Purpose  : Requester ports (SNES, loader, backup) plus SDRAM controller port
//            for main_ram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface main_ram_arbiter_if #(
  parameter int ADDR_W = 25
);
  logic              snes_req;
  logic              snes_we;
  logic              snes_word;
  logic [ADDR_W-1:0] snes_addr;
  logic [15:0]       snes_wdata;
  logic              snes_ack;
  logic [15:0]       snes_rdata;

  logic              load_req;
  logic              load_we;
  logic              load_word;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       load_wdata;
  logic              load_ack;
  logic [15:0]       load_rdata;

  logic              bk_req;
  logic              bk_we;
  logic [19:0]       bk_addr;
  logic [7:0]        bk_wdata;
  logic              bk_ack;
  logic [7:0]        bk_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic              mem_word;
  logic              mem_rd;
  logic              mem_wr;
  logic [15:0]       mem_dout;
  logic              mem_busy;
  logic [1:0]        grant;

  modport slave (
    input  snes_req, snes_we, snes_word, snes_addr, snes_wdata,
    output snes_ack, snes_rdata,
    input  load_req, load_we, load_word, load_addr, load_wdata,
    output load_ack, load_rdata,
    input  bk_req, bk_we, bk_addr, bk_wdata,
    output bk_ack, bk_rdata,
    output mem_addr, mem_din, mem_word, mem_rd, mem_wr, grant,
    input  mem_dout, mem_busy
  );

  modport master (
    output snes_req, snes_we, snes_word, snes_addr, snes_wdata,
    input  snes_ack, snes_rdata,
    output load_req, load_we, load_word, load_addr, load_wdata,
    input  load_ack, load_rdata,
    output bk_req, bk_we, bk_addr, bk_wdata,
    input  bk_ack, bk_rdata,
    input  mem_addr, mem_din, mem_word, mem_rd, mem_wr, grant,
    output mem_dout, mem_busy
  );
endinterface
`default_nettype wire

// File: rtl/main_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : main_ram_arbiter
// Purpose  : Registered priority arbiter (SNES > loader > backup, with backup
//            anti-starvation) sharing one SDRAM controller port.
// Revision : 1.0 - initial release
// ============================================================================
module main_ram_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int STARVE_MAX = 8,
  parameter int BUSY_WAIT  = 3
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  main_ram_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_ISSUE      = 2'd1;
  localparam logic [1:0] S_WAIT_START = 2'd2;
  localparam logic [1:0] S_WAIT_DONE  = 2'd3;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_SNES = 2'd1;
  localparam logic [1:0] G_LOAD = 2'd2;
  localparam logic [1:0] G_BK   = 2'd3;

  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);
  localparam logic [3:0] c_wait_last  = 4'(BUSY_WAIT - 1);

  logic [1:0]        r_state, w_state_nxt;
  logic [1:0]        r_grant, w_win;
  logic [3:0]        r_starve, r_wait;
  logic              r_mem_rd, r_mem_wr, r_mem_word;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_din;
  logic              r_snes_ack, r_load_ack, r_bk_ack;
  logic [15:0]       r_snes_rdata, r_load_rdata;
  logic [7:0]        r_bk_rdata;

  logic              w_ack_pending, w_done, w_grant_now;
  logic              w_win_we, w_win_word;
  logic [ADDR_W-1:0] w_win_addr;
  logic [15:0]       w_win_din;
  logic              w_rd_nxt, w_wr_nxt;
  logic              w_snes_ack_nxt, w_load_ack_nxt, w_bk_ack_nxt;

  // No grant during an ack cycle: the acked requester may still show req high.
  always_comb begin
    w_ack_pending = r_snes_ack | r_load_ack | r_bk_ack;
    w_win         = G_NONE;
    if (!w_ack_pending) begin
      if (bus.bk_req && (r_starve >= c_starve_max)) w_win = G_BK;
      else if (bus.snes_req)                          w_win = G_SNES;
      else if (bus.load_req)                          w_win = G_LOAD;
      else if (bus.bk_req)                            w_win = G_BK;
    end
    w_done = ((r_state == S_WAIT_DONE) && !bus.mem_busy) ||
             ((r_state == S_WAIT_START) && !bus.mem_busy && (r_wait == c_wait_last));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:       if (w_win != G_NONE) w_state_nxt = S_ISSUE;
      S_ISSUE:      w_state_nxt = S_WAIT_START;
      S_WAIT_START: begin
        if (bus.mem_busy) w_state_nxt = S_WAIT_DONE;
        else if (w_done)  w_state_nxt = S_IDLE;
      end
      S_WAIT_DONE:  if (w_done) w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_win_we   = bus.snes_we;
    w_win_word = bus.snes_word;
    w_win_addr = bus.snes_addr;
    w_win_din  = bus.snes_wdata;
    case (w_win)
      G_LOAD: begin
        w_win_we   = bus.load_we;
        w_win_word = bus.load_word;
        w_win_addr = bus.load_addr;
        w_win_din  = bus.load_wdata;
      end
      G_BK: begin
        w_win_we   = bus.bk_we;
        w_win_word = 1'b0;
        w_win_addr = ADDR_W'({5'b10000, bus.bk_addr});
        w_win_din  = {bus.bk_wdata, bus.bk_wdata};
      end
      default: ;
    endcase
    w_grant_now    = (r_state == S_IDLE) && (w_win != G_NONE);
    w_rd_nxt       = w_grant_now && !w_win_we;
    w_wr_nxt       = w_grant_now && w_win_we;
    w_snes_ack_nxt = w_done && (r_grant == G_SNES);
    w_load_ack_nxt = w_done && (r_grant == G_LOAD);
    w_bk_ack_nxt   = w_done && (r_grant == G_BK);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_grant      <= G_NONE;
      r_starve     <= 4'd0;
      r_wait       <= 4'd0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_word   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= 16'd0;
      r_snes_ack   <= 1'b0;
      r_load_ack   <= 1'b0;
      r_bk_ack     <= 1'b0;
      r_snes_rdata <= 16'd0;
      r_load_rdata <= 16'd0;
      r_bk_rdata   <= 8'd0;
    end else begin
      r_mem_rd   <= w_rd_nxt;
      r_mem_wr   <= w_wr_nxt;
      r_snes_ack <= w_snes_ack_nxt;
      r_load_ack <= w_load_ack_nxt;
      r_bk_ack   <= w_bk_ack_nxt;

      if (w_grant_now) begin
        r_grant    <= w_win;
        r_mem_word <= w_win_word;
        r_mem_addr <= w_win_addr;
        r_mem_din  <= w_win_din;
      end else if (w_done) begin
        r_grant <= G_NONE;
      end

      if (w_snes_ack_nxt) r_snes_rdata <= bus.mem_dout;
      if (w_load_ack_nxt) r_load_rdata <= bus.mem_dout;
      if (w_bk_ack_nxt)   r_bk_rdata   <= bus.mem_dout[7:0];

      if (r_state == S_WAIT_START) r_wait <= r_wait + 4'd1;
      else                         r_wait <= 4'd0;

      // Starvation counter tracks only grants that bypassed a waiting backup.
      if (!bus.bk_req) begin
        r_starve <= 4'd0;
      end else if (w_grant_now) begin
        if (w_win == G_BK)          r_starve <= 4'd0;
        else if (r_starve != 4'hF)  r_starve <= r_starve + 4'd1;
      end
    end
  end

  assign bus.mem_rd     = r_mem_rd;
  assign bus.mem_wr     = r_mem_wr;
  assign bus.mem_word   = r_mem_word;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_din    = r_mem_din;
  assign bus.grant      = r_grant;
  assign bus.snes_ack   = r_snes_ack;
  assign bus.load_ack   = r_load_ack;
  assign bus.bk_ack     = r_bk_ack;
  assign bus.snes_rdata = r_snes_rdata;
  assign bus.load_rdata = r_load_rdata;
  assign bus.bk_rdata   = r_bk_rdata;
endmodule
`default_nettype wire

// File: tb/tb_main_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_ram_arbiter
// Purpose  : Directed self-checking bench for main_ram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_ram_arbiter;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  int   busy_len;
  int   busy_cnt;

  main_ram_arbiter_if #(.ADDR_W(25)) bus ();

  main_ram_arbiter #(
    .ADDR_W    (25),
    .STARVE_MAX(8),
    .BUSY_WAIT (3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SDRAM controller model: busy rises the cycle after a command, for busy_len cycles.
  always @(posedge clk) begin
    if (bus.mem_rd || bus.mem_wr) begin
      busy_cnt     <= busy_len;
      bus.mem_busy <= (busy_len > 0);
    end else if (busy_cnt > 1) begin
      busy_cnt     <= busy_cnt - 1;
      bus.mem_busy <= 1'b1;
    end else begin
      busy_cnt     <= 0;
      bus.mem_busy <= 1'b0;
    end
  end

  task automatic wait_ack(input int which, input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if ((which == 1 && bus.snes_ack) || (which == 2 && bus.load_ack) ||
          (which == 3 && bus.bk_ack)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int c;
    reset_n      = 1'b0;
    busy_len     = 3;
    bus.snes_req = 1'b1;
    bus.load_req = 1'b1;
    bus.load_we  = 1'b1;
    bus.bk_req   = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if ({bus.snes_ack, bus.load_ack, bus.bk_ack, bus.mem_rd, bus.mem_wr} !== 5'b0 ||
          bus.grant !== 2'd0 || bus.mem_addr !== 25'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: acks/rd/wr=%b grant=%0d addr=%h, required 00000/0/0",
                 {bus.snes_ack, bus.load_ack, bus.bk_ack, bus.mem_rd, bus.mem_wr},
                 bus.grant, bus.mem_addr);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.grant !== 2'd1 || bus.mem_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%0d mem_rd=%b, required 1/1", bus.grant, bus.mem_rd);
    end
    bus.snes_req = 1'b0;
    bus.load_req = 1'b0;
    bus.bk_req   = 1'b0;
    wait_ack(1, 30, c);
    n_checks++;
    if (c < 0) begin
      n_fail++;
      $display("FAIL reset_dropped_req_ack: no snes_ack within 30 cycles, required one");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_snes_read();
    int rd_n, wr_n, ack_n, ack_cyc;
    rd_n = 0; wr_n = 0; ack_n = 0; ack_cyc = -1;
    busy_len       = 5;
    bus.mem_dout   = 16'hBEEF;
    bus.snes_addr  = 25'h0012345;
    bus.snes_word  = 1'b1;
    bus.snes_we    = 1'b0;
    bus.snes_req   = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (bus.mem_rd) begin
        rd_n++;
        n_checks++;
        if (bus.mem_addr !== 25'h0012345 || bus.mem_word !== 1'b1) begin
          n_fail++;
          $display("FAIL snes_read_cmd: addr=%h word=%b, required 0012345/1", bus.mem_addr, bus.mem_word);
        end
      end
      if (bus.mem_wr) wr_n++;
      if (bus.snes_ack) begin
        ack_n++;
        if (ack_cyc < 0) ack_cyc = c;
        bus.snes_req = 1'b0;
        n_checks++;
        if (bus.snes_rdata !== 16'hBEEF) begin
          n_fail++;
          $display("FAIL snes_read_data: rdata=%h, required beef", bus.snes_rdata);
        end
      end
    end
    n_checks++;
    if (rd_n !== 1 || wr_n !== 0 || ack_n !== 1) begin
      n_fail++;
      $display("FAIL snes_read_pulses: rd=%0d wr=%0d ack=%0d, required 1/0/1", rd_n, wr_n, ack_n);
    end
    n_checks++;
    if (ack_cyc !== 8) begin
      n_fail++;
      $display("FAIL snes_read_latency: ack at cycle %0d, required 8", ack_cyc);
    end
    bus.mem_dout = 16'h0000;
    @(negedge clk);
    n_checks++;
    if (bus.snes_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL snes_rdata_hold: rdata=%h, required beef", bus.snes_rdata);
    end
  endtask

  task automatic test_bk_write();
    int rd_n, wr_n, ack_n;
    rd_n = 0; wr_n = 0; ack_n = 0;
    busy_len     = 2;
    bus.bk_addr  = 20'h00010;
    bus.bk_wdata = 8'h5A;
    bus.bk_we    = 1'b1;
    bus.bk_req   = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (bus.mem_wr) begin
        wr_n++;
        n_checks++;
        if (bus.mem_addr !== 25'h1000010 || bus.mem_din !== 16'h5A5A ||
            bus.mem_word !== 1'b0 || bus.grant !== 2'd3) begin
          n_fail++;
          $display("FAIL bk_write_cmd: addr=%h din=%h word=%b grant=%0d, required 1000010/5a5a/0/3",
                   bus.mem_addr, bus.mem_din, bus.mem_word, bus.grant);
        end
      end
      if (bus.mem_rd) rd_n++;
      if (bus.bk_ack) begin
        ack_n++;
        bus.bk_req = 1'b0;
      end
    end
    n_checks++;
    if (wr_n !== 1 || rd_n !== 0 || ack_n !== 1) begin
      n_fail++;
      $display("FAIL bk_write_pulses: wr=%0d rd=%0d ack=%0d, required 1/0/1", wr_n, rd_n, ack_n);
    end
  endtask

  task automatic test_contention();
    int s_before, s_after, bk_n, ld_n;
    bit bk_seen, ld_seen, done;
    s_before = 0; s_after = 0; bk_n = 0; ld_n = 0;
    bk_seen = 1'b0; ld_seen = 1'b0; done = 1'b0;
    busy_len       = 1;
    bus.mem_dout   = 16'h0F0F;
    bus.snes_addr  = 25'h0000100;
    bus.snes_we    = 1'b0;
    bus.snes_word  = 1'b1;
    bus.load_addr  = 25'h0000200;
    bus.load_we    = 1'b1;
    bus.load_word  = 1'b1;
    bus.load_wdata = 16'hA5A5;
    bus.bk_addr    = 20'h00003;
    bus.bk_we      = 1'b0;
    bus.snes_req   = 1'b1;
    bus.load_req   = 1'b1;
    bus.bk_req     = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_rd || bus.mem_wr) begin
        if (bus.grant == 2'd1) begin
          if (bk_seen) s_after++;
          else s_before++;
        end else if (bus.grant == 2'd3 && !bk_seen) begin
          bk_seen = 1'b1;
          n_checks++;
          if (s_before !== 8) begin
            n_fail++;
            $display("FAIL starve_promotion: backup after %0d snes grants, required 8", s_before);
          end
        end else if (bus.grant == 2'd2 && !ld_seen) begin
          ld_seen = 1'b1;
          n_checks++;
          if (bus.snes_req !== 1'b0 || s_after < 2) begin
            n_fail++;
            $display("FAIL loader_priority: loader granted with snes_req=%b after %0d snes grants, required 0/>=2",
                     bus.snes_req, s_after);
          end
        end
      end
      if (bus.bk_ack) begin
        bk_n++;
        bus.bk_req = 1'b0;
      end
      if (bus.snes_ack && s_after >= 2) bus.snes_req = 1'b0;
      if (bus.load_ack) begin
        ld_n++;
        bus.load_req = 1'b0;
        done = 1'b1;
      end
    end
    n_checks++;
    if (!bk_seen || !ld_seen || bk_n !== 1 || ld_n !== 1) begin
      n_fail++;
      $display("FAIL contention_completion: bk_granted=%b ld_granted=%b bk_acks=%0d ld_acks=%0d, required 1/1/1/1",
               bk_seen, ld_seen, bk_n, ld_n);
    end
    bus.snes_req = 1'b0;
    bus.load_req = 1'b0;
    bus.bk_req   = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout_back_to_back();
    int iss[2];
    int acks[2];
    int ni, na;
    ni = 0; na = 0;
    iss[0] = -1; iss[1] = -1; acks[0] = -1; acks[1] = -1;
    busy_len       = 0;
    bus.mem_dout   = 16'h5555;
    bus.snes_addr  = 25'h00000AB;
    bus.snes_word  = 1'b0;
    bus.snes_we    = 1'b1;
    bus.snes_wdata = 16'h1234;
    bus.snes_req   = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (bus.mem_wr) begin
        if (ni < 2) iss[ni] = c;
        ni++;
        n_checks++;
        if (bus.mem_word !== 1'b0 || bus.mem_din !== 16'h1234) begin
          n_fail++;
          $display("FAIL timeout_cmd: word=%b din=%h, required 0/1234", bus.mem_word, bus.mem_din);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (bus.grant !== 2'd0 || bus.mem_wr !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_gap: grant=%0d mem_wr=%b at cycle 6, required 0/0", bus.grant, bus.mem_wr);
        end
      end
      if (bus.snes_ack) begin
        if (na < 2) acks[na] = c;
        na++;
        if (na == 2) bus.snes_req = 1'b0;
      end
    end
    n_checks++;
    if (acks[0] !== 5 || acks[1] !== 11 || na !== 2) begin
      n_fail++;
      $display("FAIL busy_timeout: acks at %0d,%0d count %0d, required 5,11 count 2", acks[0], acks[1], na);
    end
    n_checks++;
    if (iss[0] !== 1 || iss[1] !== 7 || ni !== 2) begin
      n_fail++;
      $display("FAIL back_to_back_issue: issues at %0d,%0d count %0d, required 1,7 count 2", iss[0], iss[1], ni);
    end
  endtask

  task automatic test_reset_mid();
    int ack_n, iss, ack_cyc;
    ack_n = 0; iss = -1; ack_cyc = -1;
    busy_len      = 12;
    bus.mem_dout  = 16'hCAFE;
    bus.snes_addr = 25'h0000777;
    bus.snes_we   = 1'b0;
    bus.snes_req  = 1'b1;
    repeat (5) @(negedge clk);
    reset_n      = 1'b0;
    bus.snes_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.snes_ack || bus.load_ack || bus.bk_ack) ack_n++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.snes_ack || bus.load_ack || bus.bk_ack) ack_n++;
    end
    n_checks++;
    if (ack_n !== 0 || bus.grant !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_abandon: acks=%0d grant=%0d, required 0/0", ack_n, bus.grant);
    end
    busy_len     = 2;
    bus.mem_dout = 16'h1234;
    bus.bk_addr  = 20'h00002;
    bus.bk_we    = 1'b0;
    bus.bk_req   = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.mem_rd) begin
        iss = c;
        n_checks++;
        if (bus.mem_addr !== 25'h1000002) begin
          n_fail++;
          $display("FAIL post_reset_addr: addr=%h, required 1000002", bus.mem_addr);
        end
      end
      if (bus.bk_ack) begin
        ack_cyc    = c;
        bus.bk_req = 1'b0;
        n_checks++;
        if (bus.bk_rdata !== 8'h34) begin
          n_fail++;
          $display("FAIL post_reset_rdata: bk_rdata=%h, required 34", bus.bk_rdata);
        end
      end
    end
    n_checks++;
    if (iss !== 1 || ack_cyc !== 5) begin
      n_fail++;
      $display("FAIL post_reset_timing: issue %0d ack %0d, required 1/5", iss, ack_cyc);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    busy_len       = 0;
    busy_cnt       = 0;
    reset_n        = 1'b0;
    bus.snes_req   = 1'b0;
    bus.snes_we    = 1'b0;
    bus.snes_word  = 1'b0;
    bus.snes_addr  = 25'd0;
    bus.snes_wdata = 16'd0;
    bus.load_req   = 1'b0;
    bus.load_we    = 1'b0;
    bus.load_word  = 1'b0;
    bus.load_addr  = 25'd0;
    bus.load_wdata = 16'd0;
    bus.bk_req     = 1'b0;
    bus.bk_we      = 1'b0;
    bus.bk_addr    = 20'd0;
    bus.bk_wdata   = 8'd0;
    bus.mem_dout   = 16'd0;
    @(negedge clk);
    test_reset();
    test_snes_read();
    test_bk_write();
    test_contention();
    test_timeout_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
